// File: rtl/dac_sequencer_pkg.sv
// Shared constants for the DAC waveform sequencer: data/address widths,
// frame limits and FSM state encoding.
package dac_sequencer_pkg;

   localparam int unsigned DACDATA          = 12;
   localparam int unsigned MEMSIZE          = 255;
   localparam int unsigned ADDR_W           = 8;
   localparam int unsigned CNT_W            = 8;
   localparam int unsigned FRAME_CYCLES_MIN = 14;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_PRESENT = 3'd2;
   localparam logic [2:0] ST_STROBE  = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   // GAP down-counter load value: FETCH, PRESENT and STROBE use three clocks
   // of the frame, the counter runs from this value down to zero inclusive.
   function automatic logic [CNT_W-1:0] gap_load(input int unsigned frame_cycles);
      return CNT_W'(frame_cycles - 4);
   endfunction

endpackage

// File: rtl/dac_wave_ram.sv
// Waveform RAM: 256x12 simple dual-port, synchronous write, registered read.
// A read and write of the same address in one cycle returns the old word.
module dac_wave_ram
   import dac_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DACDATA-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [DACDATA-1:0] rd_data
);

   logic [DACDATA-1:0] mem [0:MEMSIZE];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port (read-before-write on collision)
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/dac_sequencer.sv
// DAC waveform sequencer: plays RAM addresses 0..len to a downstream
// serializer, one dac_en load strobe every FRAME_CYCLES clocks.
// Optional feature macro: DAC_SEQ_LOOP_EN adds loop_en for continuous replay.
module dac_sequencer
   import dac_sequencer_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DACDATA-1:0] wr_data,
   input  logic [ADDR_W-1:0]  len,
   input  logic               start,
   input  logic               abort,
`ifdef DAC_SEQ_LOOP_EN
   input  logic               loop_en,
`endif
   output logic [DACDATA-1:0] dac_data,
   output logic               dac_en,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  sample_idx
);

   logic [2:0]         state;
   logic [2:0]         state_d;
   logic [CNT_W-1:0]   cnt;
   logic [ADDR_W-1:0]  len_q;
   logic [DACDATA-1:0] ram_q;
   logic               idx_last;

   dac_wave_ram u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (sample_idx),
      .rd_data (ram_q)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Next-state logic; abort overrides every transition including start
   always_comb begin
      state_d  = state;
      idx_last = (sample_idx == len_q);
      case (state)
         ST_IDLE:    if (start) state_d = ST_FETCH;
         ST_FETCH:   state_d = ST_PRESENT;
         ST_PRESENT: state_d = ST_STROBE;
         ST_STROBE:  state_d = ST_GAP;
         ST_GAP: begin
            if (cnt == '0) begin
               if (idx_last) begin
`ifdef DAC_SEQ_LOOP_EN
                  state_d = loop_en ? ST_FETCH : ST_IDLE;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         default:    state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   // Registered outputs, gap counter and latched length
   always_ff @(posedge clk) begin
      if (reset) begin
         dac_data   <= '0;
         dac_en     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sample_idx <= '0;
         cnt        <= '0;
         len_q      <= '0;
      end else begin
         busy   <= (state_d != ST_IDLE);
         dac_en <= (state == ST_PRESENT) && (state_d == ST_STROBE);
         // done is registered one clock early so it shows on the GAP expiry cycle
         done   <= (state == ST_GAP) && (cnt == CNT_W'(1)) && idx_last && !abort;

         if ((state == ST_PRESENT) && (state_d == ST_STROBE)) dac_data <= ram_q;

         if (state_d == ST_GAP) begin
            if (state == ST_STROBE) cnt <= gap_load(FRAME_CYCLES);
            else                    cnt <= cnt - CNT_W'(1);
         end else begin
            cnt <= '0;
         end

         if ((state == ST_IDLE) && (state_d == ST_FETCH)) begin
            len_q      <= len;
            sample_idx <= '0;
         end else if ((state == ST_GAP) && (state_d == ST_FETCH)) begin
            sample_idx <= idx_last ? '0 : sample_idx + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dac_sequencer.sv
// Scoreboard bench for dac_sequencer: stimulus pushes expected strobe/done
// events with absolute cycle numbers, a negedge monitor pops and compares.
module tb_dac_sequencer;

   localparam int F = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [11:0] wr_data;
   logic [7:0]  len;
   logic        start;
   logic        abort;
`ifdef DAC_SEQ_LOOP_EN
   logic        loop_en;
`endif
   logic [11:0] dac_data;
   logic        dac_en;
   logic        busy;
   logic        done;
   logic [7:0]  sample_idx;

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [11:0] data;
      logic [7:0]  idx;
   } ev_t;

   ev_t         sb[$];
   logic [11:0] model_ram [0:255];
   int          cyc   = 0;
   int          n_vec = 0;
   int          n_err = 0;

   dac_sequencer #(.FRAME_CYCLES(F)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .len        (len),
      .start      (start),
      .abort      (abort),
`ifdef DAC_SEQ_LOOP_EN
      .loop_en    (loop_en),
`endif
      .dac_data   (dac_data),
      .dac_en     (dac_en),
      .busy       (busy),
      .done       (done),
      .sample_idx (sample_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe or done pulse must match the next expected event
   always @(negedge clk) begin
      ev_t e;
      if (dac_en && done) begin
         n_vec = n_vec + 1;
         n_err = n_err + 1;
         $display("FAIL overlap: dac_en and done both high at cycle %0d", cyc);
      end else if (dac_en || done) begin
         n_vec = n_vec + 1;
         if (sb.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL unexpected %s at cycle %0d (data=%h idx=%0d), none required",
                     done ? "done" : "strobe", cyc, dac_data, sample_idx);
         end else begin
            e = sb.pop_front();
            if (e.is_done != done || e.cyc != cyc ||
                (!e.is_done && (e.data != dac_data || e.idx != sample_idx))) begin
               n_err = n_err + 1;
               $display("FAIL %s event: got cyc=%0d data=%h idx=%0d, required %s cyc=%0d data=%h idx=%0d",
                        done ? "done" : "strobe", cyc, dac_data, sample_idx,
                        e.is_done ? "done" : "strobe", e.cyc, e.data, e.idx);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick(1);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_vec = n_vec + 1;
      if (act != req) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic drain();
      ev_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec = n_vec + 1;
         n_err = n_err + 1;
         $display("FAIL missing %s: required at cycle %0d data=%h idx=%0d, not seen",
                  e.is_done ? "done" : "strobe", e.cyc, e.data, e.idx);
      end
   endtask

   task automatic ram_write(input int a, input logic [11:0] d);
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = d;
      model_ram[a] = d;
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic push_strobe(input int at, input int idx, input logic [11:0] d);
      ev_t e;
      e.is_done = 1'b0; e.cyc = at; e.data = d; e.idx = 8'(idx);
      sb.push_back(e);
   endtask

   task automatic push_done(input int at);
      ev_t e;
      e.is_done = 1'b1; e.cyc = at; e.data = '0; e.idx = '0;
      sb.push_back(e);
   endtask

   task automatic play(input logic [7:0] l, output int c);
      len   = l;
      start = 1'b1;
      c     = cyc;
      tick(1);
      start = 1'b0;
      len   = 8'hA5;
   endtask

   // Full playback of 0..l from model_ram, started in cycle c
   task automatic expect_full(input int c, input int l);
      for (int i = 0; i <= l; i++) push_strobe(c + 3 + i * F, i, model_ram[i]);
      push_done(c + (l + 1) * F);
   endtask

   initial begin
      int c;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len = '0; start = 1'b0; abort = 1'b0;
`ifdef DAC_SEQ_LOOP_EN
      loop_en = 1'b0;
`endif
      tick(3);
      check("reset dac_data", int'(dac_data), 0);
      check("reset dac_en", int'(dac_en), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset sample_idx", int'(sample_idx), 0);
      reset = 1'b0;
      tick(1);

      // Three-sample playback; a start during playback must be ignored
      ram_write(0, 12'h000); ram_write(1, 12'hABC); ram_write(2, 12'hFFF);
      ram_write(3, 12'h123); ram_write(4, 12'h456); ram_write(5, 12'h789);
      play(8'd2, c);
      expect_full(c, 2);
      check("busy after start", int'(busy), 1);
      tick(8);
      len = 8'd0; start = 1'b1; tick(1); start = 1'b0;
      wait_until(c + 3 * F + 1);
      check("busy after done len2", int'(busy), 0);
      check("dac_data held in idle", int'(dac_data), 'hFFF);
      drain();

      // Single-sample playback (len=0)
      ram_write(0, 12'h5A5);
      play(8'd0, c);
      expect_full(c, 0);
      wait_until(c + F + 1);
      check("busy after done len0", int'(busy), 0);
      check("dac_data len0", int'(dac_data), 'h5A5);
      drain();

      // Abort in the GAP of sample 1
      play(8'd5, c);
      push_strobe(c + 3, 0, model_ram[0]);
      push_strobe(c + 3 + F, 1, model_ram[1]);
      wait_until(c + 3 + F + 5);
      abort = 1'b1; tick(1); abort = 1'b0;
      check("busy after abort", int'(busy), 0);
      check("dac_data after abort", int'(dac_data), int'(model_ram[1]));
      tick(3 * F);
      drain();

      // Start and abort together in IDLE
      len = 8'd3; start = 1'b1; abort = 1'b1; tick(1);
      start = 1'b0; abort = 1'b0;
      check("busy start+abort", int'(busy), 0);
      tick(2 * F);
      check("busy later start+abort", int'(busy), 0);
      drain();

      // Write to address 1 in the same cycle it is fetched: old word is played
      play(8'd1, c);
      push_strobe(c + 3, 0, model_ram[0]);
      push_strobe(c + 3 + F, 1, 12'hABC);
      push_done(c + 2 * F);
      wait_until(c + F + 1);
      ram_write(1, 12'hDEF);
      wait_until(c + 2 * F + 1);
      drain();

      // Reset asserted in STROBE, then replay shows RAM survived reset
      play(8'd2, c);
      push_strobe(c + 3, 0, model_ram[0]);
      wait_until(c + 3);
      reset = 1'b1; tick(1);
      check("rst-strobe dac_data", int'(dac_data), 0);
      check("rst-strobe dac_en", int'(dac_en), 0);
      check("rst-strobe busy", int'(busy), 0);
      check("rst-strobe done", int'(done), 0);
      check("rst-strobe sample_idx", int'(sample_idx), 0);
      reset = 1'b0;
      tick(2 * F);
      drain();
      play(8'd2, c);
      expect_full(c, 2);
      wait_until(c + 3 * F + 1);
      check("replay final dac_data", int'(dac_data), 'hFFF);
      drain();

      // Full 256-sample playback, no index wrap before done
      for (int i = 0; i < 256; i++) ram_write(i, 12'(i * 37 + 11));
      play(8'd255, c);
      expect_full(c, 255);
      wait_until(c + 256 * F + 1);
      check("busy after len255", int'(busy), 0);
      check("sample_idx after len255", int'(sample_idx), 255);
      drain();

`ifdef DAC_SEQ_LOOP_EN
      // Looping: 0,1,0,1 with done at each wrap, then stop after loop_en drops
      ram_write(0, 12'h111); ram_write(1, 12'h222);
      loop_en = 1'b1;
      play(8'd1, c);
      push_strobe(c + 3, 0, 12'h111);
      push_strobe(c + 3 + F, 1, 12'h222);
      push_done(c + 2 * F);
      push_strobe(c + 3 + 2 * F, 0, 12'h111);
      push_strobe(c + 3 + 3 * F, 1, 12'h222);
      push_done(c + 4 * F);
      wait_until(c + 2 * F + 5);
      loop_en = 1'b0;
      wait_until(c + 4 * F + 1);
      check("busy after loop stop", int'(busy), 0);
      tick(2 * F);
      drain();
`endif

      tick(2);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
